// File: rtl/aes_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aes_ctrl_pkg
// Shared definitions for the AES job controller:
//   - controller state encoding (state_e)
//   - datapath widths (AES_BLK_W, ADDR_W, IDX_W, WDT_W)
//   - default NBLK / TIMEOUT values used by aes_ctrl
//   - blk_addr(): 8-bit wrapping block address helper
// ---------------------------------------------------------------------------
package aes_ctrl_pkg;

  localparam int AES_BLK_W   = 128;
  localparam int ADDR_W      = 8;
  localparam int IDX_W       = 4;
  localparam int WDT_W       = 16;
  localparam int NBLK_DEF    = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [3:0] {
    IDLE,
    KEY_LD,
    KEY_WAIT,
    RD,
    RD_WAIT,
    CORE_GO,
    CORE_WAIT,
    WR,
    NEXT
  } state_e;

  // Base plus block index; the sum is truncated to ADDR_W so 0xFF rolls to 0x00.
  function automatic logic [ADDR_W-1:0] blk_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/aes_ctrl_wdt.sv
// ---------------------------------------------------------------------------
// aes_ctrl_wdt
// Per-state watchdog counter for aes_ctrl (only built with AES_CTRL_WDT_EN).
// Ports:
//   clk, n_rst  : clock, asynchronous active-low reset
//   clear       : return the count to zero (controller not in a wait state)
//   enable      : count this cycle (controller in a wait state)
//   limit       : number of enabled cycles allowed before expiry
//   expired     : high during the limit-th consecutive enabled cycle
// ---------------------------------------------------------------------------
module aes_ctrl_wdt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count saturates so a stalled responder can never wrap it back below
  // the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compared one bit wider so a limit of zero or all-ones behaves sanely.
  assign expired = enable &&
                   (({1'b0, cnt_q} + (CNT_W + 1)'(1)) >= {1'b0, limit});

endmodule

// File: rtl/aes_ctrl.sv
// ---------------------------------------------------------------------------
// aes_ctrl
// Sequences an AES job: load the key into the core, then for each of NBLK
// blocks read it from block memory, run it through the core and write the
// result back.
// Parameters:
//   NBLK    : blocks per job (1..16)
//   TIMEOUT : watchdog limit in cycles per wait state
// Ports:
//   clk, n_rst                        : clock, asynchronous active-low reset
//   start, mode, usr_key,
//   usr_addr, usr_loc                 : job request, captured when accepted
//   done                              : high while idle
//   mem_addr/rd/wr/wdata/rdata/rvalid : block memory port
//   core_key_ld/go/mode/key/din/
//   dout/ready                        : AES core port
//   err                               : sticky watchdog abort flag
// Build option: define AES_CTRL_WDT_EN to include the watchdog; otherwise
// the wait states wait indefinitely and err is tied to 0.
// ---------------------------------------------------------------------------
module aes_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NBLK    = NBLK_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [AES_BLK_W-1:0] usr_key,
  input  logic [ADDR_W-1:0]    usr_addr,
  input  logic [ADDR_W-1:0]    usr_loc,
  output logic                 done,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [AES_BLK_W-1:0] mem_wdata,
  input  logic [AES_BLK_W-1:0] mem_rdata,
  input  logic                 mem_rvalid,
  output logic                 core_key_ld,
  output logic                 core_go,
  output logic                 core_mode,
  output logic [AES_BLK_W-1:0] core_key,
  output logic [AES_BLK_W-1:0] core_din,
  input  logic [AES_BLK_W-1:0] core_dout,
  input  logic                 core_ready,
  output logic                 err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBLK - 1);

  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [AES_BLK_W-1:0]   key_q, key_d;
  logic [ADDR_W-1:0]      src_q, src_d;
  logic [ADDR_W-1:0]      dst_q, dst_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [AES_BLK_W-1:0]   blk_q, blk_d;
  logic [AES_BLK_W-1:0]   res_q, res_d;
  logic                   wdt_hit;

  // Next-state and strobe decode. Strobes are pure functions of the state so
  // at most one can be high in any cycle, and all drop the instant reset
  // forces the state back to IDLE. Responses are only looked at in their own
  // wait state; a watchdog expiry abandons the rest of the job. The
  // block-advance decision is taken in the write cycle so each block costs
  // five cycles; NEXT is only a recovery encoding that returns to IDLE.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    key_d       = key_q;
    src_d       = src_q;
    dst_d       = dst_q;
    idx_d       = idx_q;
    blk_d       = blk_q;
    res_d       = res_q;
    done        = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    core_go     = 1'b0;
    core_key_ld = 1'b0;
    mem_addr    = '0;
    case (state_q)
      IDLE: begin
        done = 1'b1;
        if (start) begin
          mode_d  = mode;
          key_d   = usr_key;
          src_d   = usr_addr;
          dst_d   = usr_loc;
          idx_d   = '0;
          state_d = KEY_LD;
        end
      end
      KEY_LD: begin
        core_key_ld = 1'b1;
        state_d     = KEY_WAIT;
      end
      KEY_WAIT: begin
        if (core_ready) begin
          state_d = RD;
        end else if (wdt_hit) begin
          state_d = IDLE;
        end
      end
      RD: begin
        mem_rd   = 1'b1;
        mem_addr = blk_addr(src_q, idx_q);
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          blk_d   = mem_rdata;
          state_d = CORE_GO;
        end else if (wdt_hit) begin
          state_d = IDLE;
        end
      end
      CORE_GO: begin
        core_go = 1'b1;
        state_d = CORE_WAIT;
      end
      CORE_WAIT: begin
        if (core_ready) begin
          res_d   = core_dout;
          state_d = WR;
        end else if (wdt_hit) begin
          state_d = IDLE;
        end
      end
      WR: begin
        mem_wr   = 1'b1;
        mem_addr = blk_addr(dst_q, idx_q);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = RD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      key_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
    end
  end

  assign core_key  = key_q;
  assign core_mode = mode_q;
  assign core_din  = blk_q;
  assign mem_wdata = res_q;

`ifdef AES_CTRL_WDT_EN
  logic in_wait;
  logic err_q, err_d;

  assign in_wait = (state_q == KEY_WAIT) || (state_q == RD_WAIT) ||
                   (state_q == CORE_WAIT);

  // Leaving a wait state clears the count, so each wait gets a fresh budget.
  aes_ctrl_wdt #(
    .CNT_W (WDT_W)
  ) u_wdt (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (!in_wait),
    .enable  (in_wait),
    .limit   (WDT_W'(TIMEOUT)),
    .expired (wdt_hit)
  );

  // err stays set across the return to IDLE and is only cleared when the
  // next job is accepted.
  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE) && start) begin
      err_d = 1'b0;
    end else if (wdt_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign wdt_hit        = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_aes_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_ctrl
// Randomised, scoreboard-checked bench for aes_ctrl. Jobs push their expected
// key load, read addresses and write address/data into queues; a monitor pops
// and compares whenever the DUT strobes the memory or core port. Memory and
// core responders are behavioural with programmable latency; the "cipher" is
// a simple reversible mix so write data can be predicted from memory contents.
// ---------------------------------------------------------------------------
module tb_aes_ctrl;

  localparam int NB  = 4;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic         mode;
  logic [127:0] usr_key;
  logic [7:0]   usr_addr;
  logic [7:0]   usr_loc;
  logic         done;
  logic [7:0]   mem_addr;
  logic         mem_rd;
  logic         mem_wr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_rvalid;
  logic         core_key_ld;
  logic         core_go;
  logic         core_mode;
  logic [127:0] core_key;
  logic [127:0] core_din;
  logic [127:0] core_dout;
  logic         core_ready;
  logic         err;

  int checks = 0;
  int errors = 0;

  logic [127:0] mem_model [256];
  logic [128:0] exp_key_q [$];
  logic [7:0]   exp_rd_q  [$];
  logic [7:0]   exp_wa_q  [$];
  logic [127:0] exp_wd_q  [$];

  int           rd_lat    = 0;
  int           core_lat  = 0;
  bit           core_hold = 1'b0;
  logic [127:0] core_key_l;
  logic         core_mode_l;

  aes_ctrl #(
    .NBLK    (NB),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .mode        (mode),
    .usr_key     (usr_key),
    .usr_addr    (usr_addr),
    .usr_loc     (usr_loc),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .core_key_ld (core_key_ld),
    .core_go     (core_go),
    .core_mode   (core_mode),
    .core_key    (core_key),
    .core_din    (core_din),
    .core_dout   (core_dout),
    .core_ready  (core_ready),
    .err         (err)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Stand-in cipher: any deterministic function of data, key and mode will do.
  function automatic logic [127:0] fake_core(input logic [127:0] din,
                                             input logic [127:0] key,
                                             input logic         m);
    if (m) return {din[63:0], din[127:64]} ^ key;
    return din ^ ~key;
  endfunction

  // One comparison: counts it, reports it on mismatch.
  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // An event that should not have happened at all counts as a failed check.
  task automatic failEvent(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got event expected none", name);
  endtask

  // Memory responder: after each read strobe, wait rd_lat extra cycles and
  // present the stored block with a one-cycle rvalid pulse. Write strobes do
  // not modify the model, so expected read data never depends on job order.
  initial begin
    logic [7:0] ra;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (n_rst && mem_rd) begin
        ra = mem_addr;
        repeat (rd_lat + 1) @(negedge clk);
        mem_rdata  = mem_model[ra];
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Core responder: latches key/mode on key load and acknowledges; on go it
  // returns the mixed block after core_lat extra cycles unless core_hold is
  // set, in which case it never answers.
  initial begin
    logic [127:0] cd;
    core_ready = 1'b0;
    core_dout  = '0;
    forever begin
      @(negedge clk);
      if (n_rst && core_key_ld) begin
        core_key_l  = core_key;
        core_mode_l = core_mode;
        repeat (core_lat + 1) @(negedge clk);
        core_ready = 1'b1;
        @(negedge clk);
        core_ready = 1'b0;
      end else if (n_rst && core_go && !core_hold) begin
        cd = core_din;
        repeat (core_lat + 1) @(negedge clk);
        core_dout  = fake_core(cd, core_key_l, core_mode_l);
        core_ready = 1'b1;
        @(negedge clk);
        core_ready = 1'b0;
        core_dout  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Monitor: whenever a strobe is seen, pop the matching expectation and
  // compare; also checks that no two strobes overlap.
  always @(negedge clk) begin
    logic [128:0] mk;
    int           ns;
    if (n_rst) begin
      ns = int'(mem_rd) + int'(mem_wr) + int'(core_go) + int'(core_key_ld);
      if (ns > 0) checkOutput("strobe_overlap", 128'(ns > 1), 128'(0));
      if (core_key_ld) begin
        if (exp_key_q.size() == 0) failEvent("unexpected_key_ld");
        else begin
          mk = exp_key_q.pop_front();
          checkOutput("core_key", core_key, mk[127:0]);
          checkOutput("core_mode", 128'(core_mode), 128'(mk[128]));
        end
      end
      if (mem_rd) begin
        if (exp_rd_q.size() == 0) failEvent("unexpected_mem_rd");
        else checkOutput("rd_addr", 128'(mem_addr), 128'(exp_rd_q.pop_front()));
      end
      if (mem_wr) begin
        if (exp_wa_q.size() == 0) failEvent("unexpected_mem_wr");
        else begin
          checkOutput("wr_addr", 128'(mem_addr), 128'(exp_wa_q.pop_front()));
          checkOutput("wr_data", mem_wdata, exp_wd_q.pop_front());
        end
      end
    end
  end

  // Runs one job. Expected traffic: nrd reads and nwr writes at 8-bit
  // wrapping offsets from src/dst. Expected duration from the cycle after
  // start to done: key load (2) plus the key wait latency, then five cycles
  // per block plus the read and core latencies, unless exp_cycles overrides.
  // noisy scrambles start and the user inputs throughout the job; inject
  // pulses one competing start while the first block sits in CORE_WAIT.
  task automatic applyStimulus(input logic [7:0] src, input logic [7:0] dst,
                               input logic [127:0] key, input logic m,
                               input int lat_rd, input int lat_core,
                               input bit noisy, input bit inject,
                               input int nrd, input int nwr,
                               input int exp_cycles);
    int n;
    int inj;
    int want;
    n        = 0;
    inj      = 0;
    rd_lat   = lat_rd;
    core_lat = lat_core;
    exp_key_q.push_back({m, key});
    for (int i = 0; i < nrd; i++) exp_rd_q.push_back(8'(src + i));
    for (int i = 0; i < nwr; i++) begin
      exp_wa_q.push_back(8'(dst + i));
      exp_wd_q.push_back(fake_core(mem_model[8'(src + i)], key, m));
    end
    want = (exp_cycles >= 0) ? exp_cycles
                             : 2 + lat_core + NB * (5 + lat_rd + lat_core);
    @(negedge clk);
    start    = 1'b1;
    mode     = m;
    usr_key  = key;
    usr_addr = src;
    usr_loc  = dst;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_after_start", 128'(done), 128'(0));
    checkOutput("err_after_start", 128'(err), 128'(0));
    while (n < 2000) begin
      if (done) break;
      if (noisy) begin
        start    = 1'($urandom);
        mode     = 1'($urandom);
        usr_key  = {$urandom, $urandom, $urandom, $urandom};
        usr_addr = 8'($urandom);
        usr_loc  = 8'($urandom);
      end
      if (inject) begin
        if (inj == 0 && core_go) begin
          inj = 1;
        end else if (inj == 1) begin
          start    = 1'b1;
          mode     = ~m;
          usr_key  = ~key;
          usr_addr = src ^ 8'h55;
          usr_loc  = dst ^ 8'h55;
          inj      = 2;
        end else if (inj == 2) begin
          start = 1'b0;
          inj   = 3;
        end
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) failEvent("done_timeout");
    else checkOutput("job_cycles", 128'(n), 128'(want));
    checkOutput("reads_left", 128'(exp_rd_q.size()), 128'(0));
    checkOutput("writes_left", 128'(exp_wa_q.size()), 128'(0));
  endtask

  // Backstop so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] global timeout");
  end

  // Directed cases first, then randomised jobs.
  initial begin
    int nrd;
    int n;
    logic [7:0] s;
    for (int i = 0; i < 256; i++)
      mem_model[i] = {$urandom, $urandom, $urandom, $urandom};
    n_rst    = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    usr_key  = '0;
    usr_addr = '0;
    usr_loc  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_done", 128'(done), 128'(1));
    checkOutput("rst_err", 128'(err), 128'(0));
    checkOutput("rst_strobes", 128'({mem_rd, mem_wr, core_go, core_key_ld}), 128'(0));
    checkOutput("rst_mem_addr", 128'(mem_addr), 128'(0));
    checkOutput("rst_core_key", core_key, 128'(0));
    checkOutput("rst_core_din", core_din, 128'(0));
    checkOutput("rst_wdata", mem_wdata, 128'(0));
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_done", 128'(done), 128'(1));
    checkOutput("idle_strobes", 128'({mem_rd, mem_wr, core_go, core_key_ld}), 128'(0));
    checkOutput("idle_err", 128'(err), 128'(0));

    $display("[TB] basic job src=10 dst=80");
    applyStimulus(8'h10, 8'h80, {4{32'h0123_4567}}, 1'b0, 0, 0, 1'b0, 1'b0, NB, NB, 22);

    $display("[TB] wrapping job src=FE dst=FF");
    applyStimulus(8'hFE, 8'hFF, {4{32'hCAFE_F00D}}, 1'b1, 0, 0, 1'b0, 1'b0, NB, NB, 22);

    $display("[TB] competing start during CORE_WAIT");
    applyStimulus(8'h20, 8'h30, {4{32'h1357_9BDF}}, 1'b0, 0, 3, 1'b0, 1'b1, NB, NB, -1);

    $display("[TB] reset during RD_WAIT of block 2");
    rd_lat   = 3;
    core_lat = 0;
    s        = 8'h40;
    exp_key_q.push_back({1'b1, {4{32'hA5A5_5A5A}}});
    for (int i = 0; i < 3; i++) exp_rd_q.push_back(8'(s + i));
    for (int i = 0; i < 2; i++) begin
      exp_wa_q.push_back(8'(8'h90 + i));
      exp_wd_q.push_back(fake_core(mem_model[8'(s + i)], {4{32'hA5A5_5A5A}}, 1'b1));
    end
    @(negedge clk);
    start    = 1'b1;
    mode     = 1'b1;
    usr_key  = {4{32'hA5A5_5A5A}};
    usr_addr = s;
    usr_loc  = 8'h90;
    @(negedge clk);
    start = 1'b0;
    nrd   = 0;
    n     = 0;
    while (nrd < 3 && n < 500) begin
      if (mem_rd) nrd++;
      if (nrd < 3) begin
        @(negedge clk);
        n++;
      end
    end
    if (nrd < 3) failEvent("third_read_timeout");
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    checkOutput("midrst_done", 128'(done), 128'(1));
    checkOutput("midrst_strobes", 128'({mem_rd, mem_wr, core_go, core_key_ld}), 128'(0));
    checkOutput("midrst_mem_addr", 128'(mem_addr), 128'(0));
    checkOutput("midrst_core_key", core_key, 128'(0));
    checkOutput("midrst_writes_left", 128'(exp_wa_q.size()), 128'(0));
    exp_key_q.delete();
    exp_rd_q.delete();
    exp_wa_q.delete();
    exp_wd_q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("post_rst_done", 128'(done), 128'(1));
    applyStimulus(8'h50, 8'h60, {4{32'h0F0F_1234}}, 1'b0, 0, 0, 1'b0, 1'b0, NB, NB, 22);

`ifdef AES_CTRL_WDT_EN
    $display("[TB] watchdog abort in CORE_WAIT");
    core_hold = 1'b1;
    applyStimulus(8'h70, 8'h78, {4{32'h7777_8888}}, 1'b0, 0, 0, 1'b0, 1'b0, 1, 0, 5 + TMO);
    checkOutput("wdt_err_set", 128'(err), 128'(1));
    core_hold = 1'b0;
    applyStimulus(8'h71, 8'h79, {4{32'h9999_AAAA}}, 1'b1, 0, 0, 1'b0, 1'b0, NB, NB, 22);
`endif

    $display("[TB] random jobs");
    for (int j = 0; j < 10; j++) begin
      applyStimulus(8'($urandom), 8'($urandom),
                    {$urandom, $urandom, $urandom, $urandom}, 1'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'b1, 1'b0, NB, NB, -1);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_ctrl.md
AES_CTRL -- requirements
Module: aes_ctrl

Interface
REQ-001 SHALL have parameter NBLK, default 4, meaning the number of 128-bit blocks processed per start (1..16).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the watchdog limit in cycles per wait state (used only with AES_CTRL_WDT_EN).
REQ-003 clk  in  1  single system clock, all logic on rising edge.
REQ-004 n_rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  job request from SPI slave; sampled only in IDLE.
REQ-006 mode  in  1  0 = encrypt, 1 = decrypt; captured at start.
REQ-007 usr_key  in  128  cipher key; captured at start.
REQ-008 usr_addr  in  8  source block base address; captured at start.
REQ-009 usr_loc  in  8  destination block base address; captured at start.
REQ-010 done  out  1  idle/complete indicator returned to SPI slave (drives miso and clears its shifter).
REQ-011 mem_addr  out  8;  mem_rd  out  1;  mem_wr  out  1;  mem_wdata  out  128;  mem_rdata  in  128;  mem_rvalid  in  1: block memory port.
REQ-012 core_key_ld  out  1;  core_go  out  1;  core_mode  out  1;  core_key  out  128;  core_din  out  128;  core_dout  in  128;  core_ready  in  1: AES core port.
REQ-013 err  out  1  watchdog abort flag (held 0 when AES_CTRL_WDT_EN is undefined).

Function
REQ-014 SHALL implement states IDLE, KEY_LD, KEY_WAIT, RD, RD_WAIT, CORE_GO, CORE_WAIT, WR, NEXT.
REQ-015 IDLE: done=1; on start=1, SHALL capture mode/usr_key/usr_addr/usr_loc, clear the block index, and go to KEY_LD; done SHALL be 0 from the next cycle.
REQ-016 KEY_LD: core_key_ld=1 for exactly one cycle, core_key=captured key, core_mode=captured mode; then KEY_WAIT.
REQ-017 KEY_WAIT: SHALL wait for core_ready=1, then go to RD.
REQ-018 RD: mem_rd=1 for one cycle, mem_addr=(src+idx) mod 256; then RD_WAIT.
REQ-019 RD_WAIT: on mem_rvalid=1, SHALL latch mem_rdata into the block register, then go to CORE_GO.
REQ-020 CORE_GO: core_go=1 for one cycle with core_din=block register; then CORE_WAIT.
REQ-021 CORE_WAIT: on core_ready=1, SHALL latch core_dout, then go to WR.
REQ-022 WR: mem_wr=1 for one cycle, mem_addr=(dst+idx) mod 256, mem_wdata=latched result; then NEXT.
REQ-023 NEXT: if idx==NBLK-1, go to IDLE (done=1 the following cycle); else idx+1 and go to RD.
REQ-024 Address arithmetic SHALL be 8-bit and wrap 0xFF->0x00 without error.
REQ-025 start asserted in any non-IDLE state SHALL be ignored; the captured values SHALL NOT change mid-job.
REQ-026 mem_rvalid or core_ready arriving outside their wait states SHALL be ignored.
REQ-027 mem_rd, mem_wr, core_go and core_key_ld SHALL be mutually exclusive and never high simultaneously.
REQ-028 A job with NBLK blocks and zero-latency responders SHALL complete in 2+5*NBLK cycles from start to done.

Reset
REQ-029 On n_rst=0: state=IDLE, done=1, err=0, all strobes=0, mem_addr=0, and all data and captured registers=0.
REQ-030 Reset asserted mid-job SHALL abort immediately with no further memory write; done=1 on release.

Configuration
REQ-031 Macro AES_CTRL_WDT_EN: when defined, a per-state counter SHALL run in KEY_WAIT, RD_WAIT and CORE_WAIT. When it reaches TIMEOUT, the block SHALL set err=1 (sticky until the next accepted start), skip the remaining blocks, and return to IDLE.
REQ-032 Without AES_CTRL_WDT_EN, no watchdog logic SHALL exist, the wait states SHALL wait indefinitely, and err SHALL be tied to 0.

Structure
REQ-033 Package aes_ctrl_pkg SHALL hold the state enum, AES_BLK_W=128, ADDR_W=8, and the default NBLK/TIMEOUT constants.
REQ-034 The watchdog SHALL be sub-module aes_ctrl_wdt (clear, enable, limit, expired), instantiated only under AES_CTRL_WDT_EN.

Verification
REQ-035 Reset then idle: done=1, all strobes 0, err=0.
REQ-036 NBLK=4, src=0x10, dst=0x80, immediate responders: reads at 0x10..0x13, writes at 0x80..0x83 with core_dout data, done rises 22 cycles after start.
REQ-037 src=0xFE, dst=0xFF, NBLK=4: read addresses 0xFE,0xFF,0x00,0x01; write addresses 0xFF,0x00,0x01,0x02.
REQ-038 Second start pulsed during CORE_WAIT with a different key: ignored; all four writes use the first job's key and addresses.
REQ-039 n_rst pulsed low during RD_WAIT of block 2: no further mem_wr, done=1 after release, and a new job then runs cleanly.
REQ-040 With AES_CTRL_WDT_EN and TIMEOUT=8, core_ready held low: err=1 and return to IDLE after 8 cycles in CORE_WAIT; err clears on the next start.
